// File: rtl/config_chain_loader_if.sv
// ----------------------------------------------------------------------------
// config_chain_loader_if
// Word stream from the bitstream port / fabric config bus into the
// configuration chain loader.
//
// Signals:
//   in_data  : bitstream word, WORD_WIDTH bits            (master -> slave)
//   in_valid : in_data holds a word                       (master -> slave)
//   in_ready : loader accepts a word in this cycle        (slave  -> master)
// A word transfers on a rising clock edge where in_valid and in_ready are
// both high.
// ----------------------------------------------------------------------------
interface config_chain_loader_if #(
    parameter int WORD_WIDTH = 8
) ();
    logic [WORD_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/config_chain_loader.sv
// ----------------------------------------------------------------------------
// config_chain_loader
// Loads one tile's serial configuration shift chain from a word-wide
// bitstream. A start request clears the chain for one cycle. Words are then
// accepted one at a time and shifted out MSB-first until exactly
// CHAIN_LENGTH bits have been driven, after which done pulses for one cycle.
// Bits of the final word beyond CHAIN_LENGTH are dropped.
//
// Ports:
//   clock         : system clock, all state on the rising edge
//   nreset        : asynchronous active-low reset
//   start         : one-cycle load request, only honoured while idle
//   abort         : cancels a load in progress (no done pulse)
//   stream        : word stream (in_data / in_valid / in_ready), slave side
//   config_data   : serial bit to the chain's data_in
//   config_enable : shift enable to the chain
//   config_nreset : synchronous active-low clear to the chain
//   busy          : high from start acceptance until the return to idle
//   done          : one-cycle pulse after the final bit has been shifted
//
// Every output is a flop loaded from the value the FSM is about to enter,
// so outputs line up with the state register and no input reaches an output
// combinationally.
// ----------------------------------------------------------------------------
module config_chain_loader #(
    parameter int CHAIN_LENGTH = 524,
    parameter int WORD_WIDTH   = 8
) (
    input  logic                 clock,
    input  logic                 nreset,
    input  logic                 start,
    input  logic                 abort,
    config_chain_loader_if.slave stream,
    output logic                 config_data,
    output logic                 config_enable,
    output logic                 config_nreset,
    output logic                 busy,
    output logic                 done
);

    localparam int BIT_CNT_W = $clog2(CHAIN_LENGTH + 1);
    localparam int SH_CNT_W  = $clog2(WORD_WIDTH + 1);

    localparam logic [BIT_CNT_W-1:0] BIT_ONE   = BIT_CNT_W'(1'b1);
    localparam logic [SH_CNT_W-1:0]  SH_ONE    = SH_CNT_W'(1'b1);
    localparam logic [BIT_CNT_W-1:0] BIT_TOTAL = BIT_CNT_W'(CHAIN_LENGTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [WORD_WIDTH-1:0] word_r;
    logic [WORD_WIDTH-1:0] word_s;
    logic [SH_CNT_W-1:0]   sh_left_r;
    logic [SH_CNT_W-1:0]   sh_left_s;
    logic [BIT_CNT_W-1:0]  bits_left_r;
    logic [BIT_CNT_W-1:0]  bits_left_s;
    logic                  accept_s;

    logic                  in_ready_r;
    logic                  config_data_r;
    logic                  config_enable_r;
    logic                  config_nreset_r;
    logic                  busy_r;
    logic                  done_r;

    logic                  in_ready_s;
    logic                  config_data_s;
    logic                  config_enable_s;
    logic                  config_nreset_s;
    logic                  busy_s;
    logic                  done_s;

    // Number of bits to shift from a freshly accepted word: a full word, or
    // only what is still owed to the chain when that is less than a word.
    function automatic logic [SH_CNT_W-1:0] word_shift_count(
        input logic [BIT_CNT_W-1:0] remaining
    );
        logic [SH_CNT_W-1:0] count;
        if (int'(remaining) >= WORD_WIDTH) begin
            count = SH_CNT_W'(WORD_WIDTH);
        end else begin
            count = SH_CNT_W'(remaining);
        end
        return count;
    endfunction

    // Next-state and datapath next values; abort beats a same-cycle accept.
    always_comb begin
        state_s     = state_r;
        word_s      = word_r;
        sh_left_s   = sh_left_r;
        bits_left_s = bits_left_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s     = ST_CLEAR;
                    bits_left_s = BIT_TOTAL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (stream.in_valid && in_ready_r) begin
                    accept_s  = 1'b1;
                    word_s    = stream.in_data;
                    sh_left_s = word_shift_count(bits_left_r);
                    state_s   = ST_SHIFT;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else begin
                    word_s      = word_r << 1'b1;
                    sh_left_s   = sh_left_r - SH_ONE;
                    bits_left_s = bits_left_r - BIT_ONE;
                    if (sh_left_r == SH_ONE) begin
                        if (bits_left_r == BIT_ONE) begin
                            state_s = ST_DONE;
                        end else begin
                            state_s = ST_LOAD;
                        end
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the state about to be entered; registered below.
    // While shifting, config_data is the MSB of the word that will be held
    // during that shift cycle.
    always_comb begin
        in_ready_s      = (state_s == ST_LOAD);
        config_enable_s = (state_s == ST_SHIFT);
        config_data_s   = (state_s == ST_SHIFT) ? word_s[WORD_WIDTH-1] : 1'b0;
        config_nreset_s = (state_s != ST_CLEAR);
        busy_s          = (state_s != ST_IDLE);
        done_s          = (state_s == ST_DONE);
    end

    // State register, datapath registers and registered outputs.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_r         <= ST_IDLE;
            word_r          <= '0;
            sh_left_r       <= '0;
            bits_left_r     <= '0;
            in_ready_r      <= 1'b0;
            config_data_r   <= 1'b0;
            config_enable_r <= 1'b0;
            config_nreset_r <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
        end else begin
            state_r         <= state_s;
            word_r          <= word_s;
            sh_left_r       <= sh_left_s;
            bits_left_r     <= bits_left_s;
            in_ready_r      <= in_ready_s;
            config_data_r   <= config_data_s;
            config_enable_r <= config_enable_s;
            config_nreset_r <= config_nreset_s;
            busy_r          <= busy_s;
            done_r          <= done_s;
        end
    end

    assign stream.in_ready = in_ready_r;
    assign config_data     = config_data_r;
    assign config_enable   = config_enable_r;
    assign config_nreset   = config_nreset_r;
    assign busy            = busy_r;
    assign done            = done_r;

endmodule

// File: tb/tb_config_chain_loader.sv
// ----------------------------------------------------------------------------
// tb_config_chain_loader
// Two loaders: a 12-bit chain (8-bit words) for the scenario tests and the
// default 524-bit chain for a long random stream. A model of the target
// chain (clear on config_nreset low, shift toward MSB on config_enable)
// is compared with the concatenation of the stream bits in arrival order.
// All observation and driving happens on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_config_chain_loader;

    localparam int S_LEN = 12;
    localparam int B_LEN = 524;
    localparam int WW    = 8;
    localparam int B_WORDS = (B_LEN + WW - 1) / WW;

    logic clock = 1'b0;
    logic nreset;
    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- small instance ----------------
    logic s_start, s_abort, s_data, s_enable, s_cfg_nreset, s_busy, s_done;
    config_chain_loader_if #(.WORD_WIDTH(WW)) s_if ();
    config_chain_loader #(.CHAIN_LENGTH(S_LEN), .WORD_WIDTH(WW)) u_small (
        .clock(clock), .nreset(nreset), .start(s_start), .abort(s_abort),
        .stream(s_if), .config_data(s_data), .config_enable(s_enable),
        .config_nreset(s_cfg_nreset), .busy(s_busy), .done(s_done)
    );

    // ---------------- default instance ----------------
    logic b_start, b_abort, b_data, b_enable, b_cfg_nreset, b_busy, b_done;
    config_chain_loader_if #(.WORD_WIDTH(WW)) b_if ();
    config_chain_loader #(.CHAIN_LENGTH(B_LEN), .WORD_WIDTH(WW)) u_big (
        .clock(clock), .nreset(nreset), .start(b_start), .abort(b_abort),
        .stream(b_if), .config_data(b_data), .config_enable(b_enable),
        .config_nreset(b_cfg_nreset), .busy(b_busy), .done(b_done)
    );

    // Observation state of the small instance
    logic [S_LEN-1:0] s_chain;
    logic             s_bits[$];
    logic [WW-1:0]    s_q[$];
    int s_ts, s_en_cnt, s_rdy_cnt, s_done_cnt, s_clr_cnt, s_clr_ts, s_done_ts;
    int s_gap_cfg, s_gap_left, s_consumed, s_abort_en;

    // Chain content expected from two stream words: first 12 bits, MSB-first.
    function automatic logic [S_LEN-1:0] exp_small(input logic [WW-1:0] w0,
                                                   input logic [WW-1:0] w1);
        logic bq[$];
        logic [S_LEN-1:0] r;
        for (int k = WW - 1; k >= 0; k--) bq.push_back(w0[k]);
        for (int k = WW - 1; k >= 0; k--) bq.push_back(w1[k]);
        r = '0;
        for (int i = 0; i < S_LEN; i++) r[S_LEN-1-i] = bq[i];
        return r;
    endfunction

    // Cycles from the start-sampling edge to the edge entering DONE:
    // 1 clear cycle, then per word (wait + accept + bits shifted).
    function automatic int exp_latency(input int len, input int gap);
        int rem, lat, b;
        rem = len;
        lat = 1;
        while (rem > 0) begin
            b = (rem < WW) ? rem : WW;
            lat += gap + 1 + b;
            rem -= b;
        end
        return lat;
    endfunction

    task automatic clear_obs_s();
        s_en_cnt = 0; s_rdy_cnt = 0; s_done_cnt = 0; s_clr_cnt = 0;
        s_clr_ts = -1; s_done_ts = -1; s_consumed = 0;
        s_bits.delete();
        s_gap_left = s_gap_cfg;
    endtask

    // One falling edge: observe the small instance, then drive its inputs.
    task automatic step_s(input logic start_v);
        @(negedge clock);
        s_ts++;
        if (s_enable) begin
            s_chain = {s_chain[S_LEN-2:0], s_data};
            s_en_cnt++;
            s_bits.push_back(s_data);
        end
        if (!s_cfg_nreset) begin
            s_chain = '0;
            s_clr_cnt++;
            s_clr_ts = s_ts;
        end
        if (s_if.in_ready) s_rdy_cnt++;
        if (s_done) begin
            s_done_cnt++;
            s_done_ts = s_ts;
        end
        s_start = start_v;
        s_abort = (s_abort_en > 0) && s_enable && (s_en_cnt == s_abort_en);
        if (s_abort) s_abort_en = 0;
        if (s_q.size() == 0) begin
            s_if.in_valid = 1'b0;
        end else if (s_gap_left > 0) begin
            s_if.in_valid = 1'b0;
            if (s_if.in_ready) s_gap_left--;
        end else begin
            s_if.in_valid = 1'b1;
            s_if.in_data  = s_q[0];
            if (s_if.in_ready && !s_abort) begin
                void'(s_q.pop_front());
                s_consumed++;
                s_gap_left = s_gap_cfg;
            end
        end
    endtask

    // Full load on the small instance; optional second start after
    // restart_at_en enable cycles. Runs a few cycles past done.
    task automatic load_small(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                              input logic [WW-1:0] w2, input int gap,
                              input int restart_at_en, output int t0);
        int fired;
        s_q.delete();
        s_q.push_back(w0); s_q.push_back(w1); s_q.push_back(w2);
        s_gap_cfg = gap;
        clear_obs_s();
        step_s(1'b1);
        t0 = s_ts;
        fired = 0;
        for (int i = 0; i < 200 && s_done_cnt == 0; i++) begin
            if (restart_at_en > 0 && fired == 0 && s_en_cnt == restart_at_en) begin
                fired = 1;
                step_s(1'b1);
            end else begin
                step_s(1'b0);
            end
        end
        for (int i = 0; i < 4; i++) step_s(1'b0);
        s_q.delete();
    endtask

    task automatic test_reset();
        nreset = 1'b1;
        #2 nreset = 1'b0;
        #1;
        n_cmp++;
        if ({s_if.in_ready, s_data, s_enable, s_cfg_nreset, s_busy, s_done} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_small: got %b expected 000000",
                     {s_if.in_ready, s_data, s_enable, s_cfg_nreset, s_busy, s_done});
        end
        n_cmp++;
        if ({b_if.in_ready, b_data, b_enable, b_cfg_nreset, b_busy, b_done} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_big: got %b expected 000000",
                     {b_if.in_ready, b_data, b_enable, b_cfg_nreset, b_busy, b_done});
        end
        step_s(1'b0);
        step_s(1'b0);
        nreset = 1'b1;
        step_s(1'b0);
        n_cmp++;
        if ({s_if.in_ready, s_enable, s_cfg_nreset, s_busy, s_done} !== 5'b00100) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b expected 00100",
                     {s_if.in_ready, s_enable, s_cfg_nreset, s_busy, s_done});
        end
    endtask

    task automatic test_basic();
        int t0;
        logic [S_LEN-1:0] seq;
        load_small(8'hA5, 8'h3C, 8'hFF, 0, 0, t0);
        seq = '0;
        foreach (s_bits[i]) if (i < S_LEN) seq[S_LEN-1-i] = s_bits[i];
        n_cmp++;
        if (seq !== 12'b1010_0101_0011) begin
            n_fail++;
            $display("FAIL basic_data_seq: got %b expected 101001010011", seq);
        end
        n_cmp++;
        if (s_en_cnt !== S_LEN) begin
            n_fail++;
            $display("FAIL basic_enable_cycles: got %0d expected %0d", s_en_cnt, S_LEN);
        end
        n_cmp++;
        if (s_chain !== exp_small(8'hA5, 8'h3C) || s_chain !== 12'hA53) begin
            n_fail++;
            $display("FAIL basic_chain: got %h expected a53", s_chain);
        end
        n_cmp++;
        if (s_done_ts - t0 - 1 !== 15) begin
            n_fail++;
            $display("FAIL basic_done_latency: got %0d expected 15", s_done_ts - t0 - 1);
        end
        n_cmp++;
        if (s_rdy_cnt !== 2 || s_consumed !== 2) begin
            n_fail++;
            $display("FAIL basic_ready_cycles: got %0d/%0d expected 2/2", s_rdy_cnt, s_consumed);
        end
        n_cmp++;
        if (s_done_cnt !== 1 || s_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_once: got %0d busy %b expected 1 busy 0", s_done_cnt, s_busy);
        end
    endtask

    task automatic test_backpressure();
        int t0;
        load_small(8'hA5, 8'h3C, 8'h00, 5, 0, t0);
        n_cmp++;
        if (s_chain !== 12'hA53 || s_en_cnt !== S_LEN) begin
            n_fail++;
            $display("FAIL bp_chain: got %h/%0d expected a53/12", s_chain, s_en_cnt);
        end
        n_cmp++;
        if (s_done_ts - t0 - 1 !== 25) begin
            n_fail++;
            $display("FAIL bp_done_latency: got %0d expected 25", s_done_ts - t0 - 1);
        end
        n_cmp++;
        if (s_rdy_cnt !== 12) begin
            n_fail++;
            $display("FAIL bp_ready_cycles: got %0d expected 12", s_rdy_cnt);
        end
    endtask

    task automatic test_clear_and_restart();
        int t0;
        logic [WW-1:0] w0, w1;
        w0 = WW'($urandom);
        w1 = WW'($urandom);
        load_small(w0, w1, 8'h5A, 0, 5, t0);
        n_cmp++;
        if (s_clr_cnt !== 1 || s_clr_ts !== t0 + 1) begin
            n_fail++;
            $display("FAIL clear_cycle: got cnt %0d at %0d expected cnt 1 at %0d",
                     s_clr_cnt, s_clr_ts, t0 + 1);
        end
        n_cmp++;
        if (s_en_cnt !== S_LEN || s_chain !== exp_small(w0, w1)) begin
            n_fail++;
            $display("FAIL restart_ignored: got %0d bits chain %h expected 12 bits chain %h",
                     s_en_cnt, s_chain, exp_small(w0, w1));
        end
        n_cmp++;
        if (s_done_cnt !== 1 || s_done_ts - t0 - 1 !== 15 || s_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_done: got cnt %0d lat %0d busy %b expected 1 15 0",
                     s_done_cnt, s_done_ts - t0 - 1, s_busy);
        end
    endtask

    task automatic test_abort();
        int t0;
        int seen;
        s_q.delete();
        s_q.push_back(8'hA5); s_q.push_back(8'h3C);
        s_gap_cfg = 0;
        clear_obs_s();
        s_abort_en = 3;
        step_s(1'b1);
        seen = 0;
        for (int i = 0; i < 60 && seen == 0; i++) begin
            step_s(1'b0);
            if (s_abort) begin
                seen = 1;
                step_s(1'b0);
                n_cmp++;
                if ({s_busy, s_enable, s_if.in_ready} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL abort_next_cycle: got %b expected 000",
                             {s_busy, s_enable, s_if.in_ready});
                end
            end
        end
        n_cmp++;
        if (seen !== 1) begin
            n_fail++;
            $display("FAIL abort_issued: got %0d expected 1", seen);
        end
        for (int i = 0; i < 30; i++) step_s(1'b0);
        n_cmp++;
        if (s_done_cnt !== 0 || s_en_cnt !== 3) begin
            n_fail++;
            $display("FAIL abort_counts: got done %0d en %0d expected 0 3", s_done_cnt, s_en_cnt);
        end
        s_abort_en = 0;
        load_small(8'hA5, 8'h3C, 8'h00, 0, 0, t0);
        n_cmp++;
        if (s_chain !== 12'hA53 || s_done_cnt !== 1) begin
            n_fail++;
            $display("FAIL abort_reload: got %h done %0d expected a53 done 1", s_chain, s_done_cnt);
        end
    endtask

    task automatic test_random();
        int t0, gap;
        logic [WW-1:0] w0, w1, w2;
        for (int it = 0; it < 4; it++) begin
            w0 = WW'($urandom);
            w1 = WW'($urandom);
            w2 = WW'($urandom);
            gap = $urandom_range(0, 3);
            load_small(w0, w1, w2, gap, 0, t0);
            n_cmp++;
            if (s_chain !== exp_small(w0, w1) || s_en_cnt !== S_LEN) begin
                n_fail++;
                $display("FAIL rand_chain[%0d]: got %h/%0d expected %h/12",
                         it, s_chain, s_en_cnt, exp_small(w0, w1));
            end
            n_cmp++;
            if (s_done_ts - t0 - 1 !== exp_latency(S_LEN, gap) || s_consumed !== 2) begin
                n_fail++;
                $display("FAIL rand_timing[%0d]: got lat %0d words %0d expected %0d 2",
                         it, s_done_ts - t0 - 1, s_consumed, exp_latency(S_LEN, gap));
            end
        end
    endtask

    task automatic test_async_reset();
        int t0;
        s_q.delete();
        s_q.push_back(8'hC3); s_q.push_back(8'h96);
        s_gap_cfg = 0;
        clear_obs_s();
        step_s(1'b1);
        t0 = s_ts;
        for (int i = 0; i < 40 && s_en_cnt < 4; i++) step_s(1'b0);
        #2 nreset = 1'b0;
        #1;
        n_cmp++;
        if ({s_if.in_ready, s_data, s_enable, s_cfg_nreset, s_busy, s_done} !== 6'b0
            || s_en_cnt !== 4) begin
            n_fail++;
            $display("FAIL async_reset: got %b after %0d bits expected 000000 after 4",
                     {s_if.in_ready, s_data, s_enable, s_cfg_nreset, s_busy, s_done}, s_en_cnt);
        end
        s_q.delete();
        step_s(1'b0);
        n_cmp++;
        if ({s_enable, s_cfg_nreset, s_busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_hold: got %b expected 000", {s_enable, s_cfg_nreset, s_busy});
        end
        nreset = 1'b1;
        clear_obs_s();
        for (int i = 0; i < 20; i++) step_s(1'b0);
        n_cmp++;
        if ({s_if.in_ready, s_enable, s_cfg_nreset, s_busy} !== 4'b0010
            || s_done_cnt !== 0 || s_en_cnt !== 0) begin
            n_fail++;
            $display("FAIL after_release: got %b done %0d en %0d expected 0010 0 0",
                     {s_if.in_ready, s_enable, s_cfg_nreset, s_busy}, s_done_cnt, s_en_cnt);
        end
    endtask

    task automatic test_defaults();
        logic [WW-1:0]    words[$];
        int               gaps[$];
        logic             exp_bits[$];
        logic [B_LEN-1:0] chain, exp_chain;
        int idx, gap_left, en_cnt, done_cnt, done_ts, ts, exp_lat, rem, b;
        for (int i = 0; i < B_WORDS; i++) begin
            words.push_back(WW'($urandom));
            gaps.push_back($urandom_range(0, 2));
        end
        foreach (words[i]) for (int k = WW - 1; k >= 0; k--) exp_bits.push_back(words[i][k]);
        exp_chain = '0;
        for (int i = 0; i < B_LEN; i++) exp_chain[B_LEN-1-i] = exp_bits[i];
        exp_lat = 1;
        rem = B_LEN;
        for (int i = 0; i < B_WORDS; i++) begin
            b = (rem < WW) ? rem : WW;
            exp_lat += gaps[i] + 1 + b;
            rem -= b;
        end
        chain = '0; idx = 0; gap_left = gaps[0];
        en_cnt = 0; done_cnt = 0; done_ts = -1; ts = 0;
        @(negedge clock);
        b_start = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clock);
            ts++;
            if (b_enable) begin
                chain = {chain[B_LEN-2:0], b_data};
                en_cnt++;
            end
            if (!b_cfg_nreset) chain = '0;
            if (b_done) begin
                done_cnt++;
                done_ts = ts;
            end
            b_start = 1'b0;
            if (idx >= B_WORDS) begin
                b_if.in_valid = 1'b0;
            end else if (gap_left > 0) begin
                b_if.in_valid = 1'b0;
                if (b_if.in_ready) gap_left--;
            end else begin
                b_if.in_valid = 1'b1;
                b_if.in_data  = words[idx];
                if (b_if.in_ready) begin
                    idx++;
                    gap_left = (idx < B_WORDS) ? gaps[idx] : 0;
                end
            end
            if (done_cnt > 0 && ts >= done_ts + 5) break;
        end
        n_cmp++;
        if (en_cnt !== B_LEN || idx !== B_WORDS) begin
            n_fail++;
            $display("FAIL big_counts: got %0d bits %0d words expected %0d bits %0d words",
                     en_cnt, idx, B_LEN, B_WORDS);
        end
        n_cmp++;
        if (chain !== exp_chain) begin
            n_fail++;
            $display("FAIL big_chain: got %h expected %h", chain, exp_chain);
        end
        n_cmp++;
        if (done_cnt !== 1 || done_ts - 1 !== exp_lat) begin
            n_fail++;
            $display("FAIL big_done: got cnt %0d lat %0d expected 1 %0d",
                     done_cnt, done_ts - 1, exp_lat);
        end
    endtask

    initial begin
        s_start = 1'b0; s_abort = 1'b0; s_if.in_valid = 1'b0; s_if.in_data = '0;
        b_start = 1'b0; b_abort = 1'b0; b_if.in_valid = 1'b0; b_if.in_data = '0;
        s_chain = '0; s_ts = 0; s_gap_cfg = 0; s_abort_en = 0;
        clear_obs_s();
        test_reset();
        test_basic();
        test_backpressure();
        test_clear_and_restart();
        test_abort();
        test_random();
        test_defaults();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
